// File: rtl/gcd_stein_unit_if.sv
// Operand/result handshake bundle for the Stein GCD engine: valid/ready in, valid/ready out.
// The engine takes the slave side; the operand source and result consumer take the master side.
interface gcd_stein_unit_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int CNT_WIDTH = $clog2(3*DATA_WIDTH+2);

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] operand_a_i;
    logic [DATA_WIDTH-1:0] operand_b_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] gcd_o;
    logic                  coprime_o;
    logic [CNT_WIDTH-1:0]  cycles_o;
    logic                  busy_o;

    modport slave (
        input  in_valid_i, operand_a_i, operand_b_i, out_ready_i,
        output in_ready_o, out_valid_o, gcd_o, coprime_o, cycles_o, busy_o
    );

    modport master (
        output in_valid_i, operand_a_i, operand_b_i, out_ready_i,
        input  in_ready_o, out_valid_o, gcd_o, coprime_o, cycles_o, busy_o
    );
endinterface

// File: rtl/gcd_stein_unit.sv
// Binary (Stein) GCD engine, one job in flight; latency 1 cycle for a zero operand, else cycles_o+1.
// Accepts only in IDLE; the result is held in DONE until out_ready_i is seen.
module gcd_stein_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    gcd_stein_unit_if.slave    bus
);
    localparam int CNT_WIDTH = $clog2(3*DATA_WIDTH+2);
    localparam int K_WIDTH   = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STRIP  = 3'd1;
    localparam logic [2:0] S_REDUCE = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [K_WIDTH-1:0]    r_k;
    logic [DATA_WIDTH-1:0] r_gcd;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [DATA_WIDTH-1:0] w_a_minus_b;
    logic [DATA_WIDTH-1:0] w_b_minus_a;
    logic                  w_accept;
    logic                  w_zero_op;

    assign w_a_minus_b = r_a - r_b;
    assign w_b_minus_a = r_b - r_a;
    assign w_accept    = bus.in_valid_i && (r_state == S_IDLE);
    assign w_zero_op   = (bus.operand_a_i == '0) || (bus.operand_b_i == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_gcd   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.operand_a_i;
                        r_b   <= bus.operand_b_i;
                        r_k   <= '0;
                        r_cnt <= '0;
                        if (w_zero_op) begin
                            r_gcd   <= bus.operand_a_i | bus.operand_b_i;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_STRIP;
                        end
                    end
                end
                S_STRIP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Both odd before any subtract, so the difference is even and the shift is exact.
                    if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a > r_b) begin
                        r_a <= w_a_minus_b >> 1;
                    end else if (r_b > r_a) begin
                        r_b <= w_b_minus_a >> 1;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_gcd   <= r_a << r_k;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == S_IDLE);
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.out_valid_o = (r_state == S_DONE);
    assign bus.gcd_o       = r_gcd;
    assign bus.coprime_o   = (r_gcd == {{(DATA_WIDTH-1){1'b0}}, 1'b1});
    assign bus.cycles_o    = r_cnt;
endmodule

// File: tb/tb_gcd_stein_unit.sv
// Directed and randomised checks of gcd_stein_unit against hand-computed values and a Euclid model.
module tb_gcd_stein_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    gcd_stein_unit_if #(.DATA_WIDTH(8)) bus ();
    gcd_stein_unit #(.DATA_WIDTH(8)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic wait_result(input string tag, output int lat);
        lat = 1;
        while (!bus.out_valid_o && lat < 100) begin
            step();
            lat++;
        end
        if (!bus.out_valid_o) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int eg, input int ecop, input int ecyc);
        int lat = 0;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        while (!bus.in_ready_o && lat < 50) begin
            step();
            lat++;
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready_o), 1);
        step();
        bus.in_valid_i  = 1'b0;
        bus.operand_a_i = 8'($urandom);
        bus.operand_b_i = 8'($urandom);
        check({tag, "_busy"}, 32'(bus.busy_o), 1);
        wait_result(tag, lat);
        check({tag, "_latency"}, lat, ecyc + 1);
        check({tag, "_gcd"}, 32'(bus.gcd_o), eg);
        check({tag, "_coprime"}, 32'(bus.coprime_o), ecop);
        check({tag, "_cycles"}, 32'(bus.cycles_o), ecyc);
        step();
        check({tag, "_vld_drop"}, 32'(bus.out_valid_o), 0);
    endtask

    initial begin
        int lat;
        int nres;
        int ga;
        int gb;
        int eg;
        bit got;
        bit rdy;

        bus.in_valid_i  = 1'b0;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        bus.out_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready_o), 1);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_out_valid", 32'(bus.out_valid_o), 0);
        check("rst_gcd", 32'(bus.gcd_o), 0);
        check("rst_coprime", 32'(bus.coprime_o), 0);
        check("rst_cycles", 32'(bus.cycles_o), 0);

        run_job("g12_18", 8'd12, 8'd18, 6, 0, 6);
        run_job("g255_1", 8'd255, 8'd1, 1, 1, 10);
        run_job("g0_5", 8'd0, 8'd5, 5, 0, 0);
        run_job("g0_0", 8'd0, 8'd0, 0, 0, 0);
        run_job("g9_0", 8'd9, 8'd0, 9, 0, 0);
        run_job("g48_36", 8'd48, 8'd36, 12, 0, 8);
        run_job("g7_7", 8'd7, 8'd7, 7, 0, 3);
        run_job("g1_1", 8'd1, 8'd1, 1, 1, 3);

        // Held result with ignored in_valid pulses, then release while a new request waits.
        step();
        bus.operand_a_i = 8'd128;
        bus.operand_b_i = 8'd64;
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b0;
        step();
        bus.operand_a_i = 8'd3;
        bus.operand_b_i = 8'd5;
        lat = 1;
        while (!bus.out_valid_o && lat < 100) begin
            check("hold_in_ready_busy", 32'(bus.in_ready_o), 0);
            bus.in_valid_i = ~bus.in_valid_i;
            step();
            lat++;
        end
        check("hold_latency", lat, 11);
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(bus.out_valid_o), 1);
            check("hold_gcd", 32'(bus.gcd_o), 64);
            check("hold_cycles", 32'(bus.cycles_o), 10);
            check("hold_in_ready", 32'(bus.in_ready_o), 0);
            step();
        end
        bus.out_ready_i = 1'b1;
        step();
        check("handoff_out_valid", 32'(bus.out_valid_o), 0);
        check("handoff_busy", 32'(bus.busy_o), 0);
        check("handoff_gcd_retained", 32'(bus.gcd_o), 64);
        step();
        bus.in_valid_i = 1'b0;
        check("next_busy", 32'(bus.busy_o), 1);
        wait_result("g3_5", lat);
        check("g3_5_gcd", 32'(bus.gcd_o), 1);
        check("g3_5_coprime", 32'(bus.coprime_o), 1);
        check("g3_5_cycles", 32'(bus.cycles_o), 5);
        step();

        // Reset in the middle of REDUCE, then rerun the same job.
        bus.operand_a_i = 8'd200;
        bus.operand_b_i = 8'd75;
        bus.in_valid_i  = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 32'(bus.busy_o), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready_o), 1);
        check("mid_rst_out_valid", 32'(bus.out_valid_o), 0);
        check("mid_rst_gcd", 32'(bus.gcd_o), 0);
        check("mid_rst_cycles", 32'(bus.cycles_o), 0);
        run_job("g200_75", 8'd200, 8'd75, 25, 0, 7);

        // Random sweep with random issue gaps and consumer backpressure.
        nres = 0;
        for (int j = 0; j < 40; j++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
            ga = (j % 8 == 0) ? 0 : int'($urandom_range(0, 255));
            gb = int'($urandom_range(0, 255));
            eg = ref_gcd(ga, gb);
            bus.operand_a_i = 8'(ga);
            bus.operand_b_i = 8'(gb);
            bus.in_valid_i  = 1'b1;
            lat = 0;
            while (!bus.in_ready_o && lat < 50) begin
                step();
                lat++;
            end
            step();
            bus.in_valid_i = 1'b0;
            got = 1'b0;
            lat = 0;
            while (!got && lat < 300) begin
                rdy = 1'($urandom);
                bus.out_ready_i = rdy;
                if (bus.out_valid_o && rdy) begin
                    check("rand_gcd", 32'(bus.gcd_o), eg);
                    check("rand_coprime", 32'(bus.coprime_o), (eg == 1) ? 1 : 0);
                    check("rand_cycles_bound", 32'(bus.cycles_o <= 5'd25), 1);
                    got = 1'b1;
                    nres++;
                end
                step();
                lat++;
            end
            bus.out_ready_i = 1'b0;
        end
        check("rand_results", nres, 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
